// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum drain controller.
package psum_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;
endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Drained-word stream (valid/ready with last marker) between the drain controller and its consumer.
interface psum_drain_ctrl_if #(
  parameter int DATA_WIDTH = psum_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] o_dat;
  logic                  o_vld;
  logic                  o_last;
  logic                  i_rdy;

  modport master (output o_dat, o_vld, o_last, input i_rdy);
  modport slave  (input o_dat, o_vld, o_last, output i_rdy);
endinterface

// File: rtl/psum_drain_fifo.sv
// Sync FIFO with a registered read port; count includes the word sitting in the output register.
module psum_drain_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       dout,
  output logic                   dvld
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wptr, rptr, rnext;
  logic          push_ok, pop_ok;
  logic [CW-1:0] cnt_n;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & dvld;
  assign push_ok = push & (~full | pop_ok);
  assign rnext   = rptr + AW'(1);
  assign cnt_n   = count + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dvld  <= 1'b0;
      dout  <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop_ok) rptr <= rnext;
      count <= cnt_n;
      dvld  <= (cnt_n != '0);
      // Output register always mirrors the head after this cycle's update.
      if (pop_ok) begin
        if (count > CW'(1)) dout <= mem[rnext];
        else if (push_ok)   dout <= din;
      end else if (empty && push_ok) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/psum_drain_ctrl.sv
// Partial-sum buffer port owner: IDLE pass-through for the accumulator, then a credit-limited drain.
// Optional PSUM_DRAIN_CLEAR_EN: zero each buffer word as its read data returns.
module psum_drain_ctrl #(
  parameter int DATA_WIDTH = psum_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = psum_pkg::ADDR_WIDTH,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] acc_wadd,
  input  logic [ADDR_WIDTH-1:0] acc_radd,
  input  logic                  acc_wren,
  input  logic                  acc_rden,
  input  logic [DATA_WIDTH-1:0] acc_idat,
  output logic [DATA_WIDTH-1:0] acc_odat,
  output logic                  acc_oval,
  input  logic                  acc_done,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_oval,
  input  logic [REG_WIDTH-1:0]  i_conf_drainlen,
  psum_drain_ctrl_if.master     drain,
  output logic                  o_busy,
  output logic                  o_drain_done,
  output logic                  o_acc_err
);
  import psum_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_t         state;
  logic                 done_q;
  logic [REG_WIDTH-1:0] len, rd_cnt, outstanding, credit;
  logic [MEM_DELAY-1:0] vld_pipe, last_pipe;
  logic [MEM_DELAY-1:0][ADDR_WIDTH-1:0] addr_pipe;

  logic                  fifo_full, fifo_empty, fifo_dvld;
  logic [CW-1:0]         fifo_cnt;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  done_rise, issue, ret, is_last, pop;

  assign done_rise = acc_done & ~done_q;
  // Every issued read owns a FIFO slot until it is popped, so returns never overflow.
  assign credit  = outstanding + REG_WIDTH'(fifo_cnt);
  assign issue   = (state == ST_DRAIN) && (credit < REG_WIDTH'(FIFO_DEPTH)) && !fifo_full;
  assign ret     = mem_oval & vld_pipe[MEM_DELAY-1];
  assign is_last = (rd_cnt == len - REG_WIDTH'(1));
  assign pop     = fifo_dvld & drain.i_rdy;

  always_comb begin
    mem_wadd = acc_wadd;
    mem_radd = acc_radd;
    mem_wren = acc_wren;
    mem_rden = acc_rden;
    mem_idat = acc_idat;
    acc_odat = mem_odat;
    acc_oval = mem_oval;
    if (state != ST_IDLE) begin
      acc_odat = '0;
      acc_oval = 1'b0;
      mem_radd = ADDR_WIDTH'(rd_cnt);
      mem_rden = issue;
`ifdef PSUM_DRAIN_CLEAR_EN
      mem_wren = ret;
`else
      mem_wren = 1'b0;
`endif
      mem_wadd = addr_pipe[MEM_DELAY-1];
      mem_idat = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= is_last;
      addr_pipe[0] <= ADDR_WIDTH'(rd_cnt);
      for (int k = 1; k < MEM_DELAY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      done_q       <= 1'b0;
      len          <= '0;
      rd_cnt       <= '0;
      outstanding  <= '0;
      o_busy       <= 1'b0;
      o_drain_done <= 1'b0;
      o_acc_err    <= 1'b0;
    end else begin
      done_q       <= acc_done;
      o_drain_done <= 1'b0;
      if (state != ST_IDLE && (acc_rden || acc_wren)) o_acc_err <= 1'b1;
      if (issue) rd_cnt <= rd_cnt + REG_WIDTH'(1);
      if (issue && !ret)      outstanding <= outstanding + REG_WIDTH'(1);
      else if (!issue && ret) outstanding <= outstanding - REG_WIDTH'(1);
      case (state)
        ST_IDLE: if (done_rise) begin
          len    <= i_conf_drainlen;
          rd_cnt <= '0;
          o_busy <= 1'b1;
          if (i_conf_drainlen == '0) begin
            state        <= ST_DONE;
            o_drain_done <= 1'b1;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (issue && (rd_cnt + REG_WIDTH'(1) == len)) state <= ST_FLUSH;
        ST_FLUSH: if (outstanding == '0 && fifo_empty) begin
          state        <= ST_DONE;
          o_drain_done <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  psum_drain_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret),
    .din   ({last_pipe[MEM_DELAY-1], mem_odat}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .dout  (fifo_dout),
    .dvld  (fifo_dvld)
  );

  assign drain.o_dat  = fifo_dout[DATA_WIDTH-1:0];
  assign drain.o_last = fifo_dout[DATA_WIDTH];
  assign drain.o_vld  = fifo_dvld;
endmodule
